// File: rtl/bm_dag_pkg.sv
// bm_dag_pkg: op encodings and the width-generic bitwise op shared by the DAG pipeline
package bm_dag_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] apply_op(
    input logic [1:0]       op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    return op == OP_AND  ? a & b :
           op == OP_OR   ? a | b :
           op == OP_XOR  ? a ^ b :
           op == OP_XNOR ? ~(a ^ b) : '0;
  endfunction
endpackage

// File: rtl/bm_dag_stage.sv
// bm_dag_stage: one enable-gated long-branch stage; extends the tb chain by xor with its own a
module bm_dag_stage
  import bm_dag_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic             v_in,
  input  logic             c_in,
  input  logic             d_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] fa_in,
  input  logic [WIDTH-1:0] tb_in,
  output logic             v_out,
  output logic             c_out,
  output logic             d_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] fa_out,
  output logic [WIDTH-1:0] tb_out
);
  logic ld;
  logic v_q, v_d, c_q, c_d, d_q, d_d;
  logic [WIDTH-1:0] a_q, a_d, fa_q, fa_d, tb_q, tb_d;
  assign ld = en & ~flush;
  always_comb begin
    v_d  = flush ? 1'b0 : en ? v_in : v_q;
    c_d  = ld ? c_in : c_q;
    d_d  = ld ? d_in : d_q;
    a_d  = ld ? a_in : a_q;
    fa_d = ld ? fa_in : fa_q;
    tb_d = ld ? tb_in : tb_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q  <= 1'b0;
      c_q  <= 1'b0;
      d_q  <= 1'b0;
      a_q  <= '0;
      fa_q <= '0;
      tb_q <= '0;
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      d_q  <= d_d;
      a_q  <= a_d;
      fa_q <= fa_d;
      tb_q <= tb_d;
    end
  end
  assign v_out  = v_q;
  assign c_out  = c_q;
  assign d_out  = d_q;
  assign a_out  = a_q;
  assign fa_out = fa_q;
  assign tb_out = a_q ^ tb_q;
endmodule

// File: rtl/bm_dag_pipe_param.sv
// bm_dag_pipe_param: elastic two-branch bitwise DAG pipeline (short op branch AND-merged with
// a DEPTH-long xor chain), with flush and a completed-handshake counter
module bm_dag_pipe_param
  import bm_dag_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out1,
  output logic [CNT_W-1:0] out_count
);
  logic en, ld, up, a_unused;
  logic v1_q, v1_d, c1_q, c1_d, d1_q, d1_d;
  logic [WIDTH-1:0] a1_q, a1_d, f1_q, f1_d;
  logic [DEPTH:1] v, c, d;
  logic [DEPTH:1][WIDTH-1:0] a, fa, tb;
  logic vo_q, vo_d, o1_q, o1_d;
  logic [WIDTH-1:0] o0_q, o0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign en       = ~vo_q | out_ready;
  assign ld       = en & ~flush;
  assign in_ready = en;
  // stage 1: both branches start from the same f(a,b), so one register serves fa and tb1
  always_comb begin
    v1_d = flush ? 1'b0 : en ? in_valid : v1_q;
    a1_d = ld ? a_in : a1_q;
    c1_d = ld ? c_in : c1_q;
    d1_d = ld ? d_in : d1_q;
    f1_d = ld ? WIDTH'(apply_op(op_sel, MAX_W'(a_in), MAX_W'(b_in))) : f1_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      c1_q <= 1'b0;
      d1_q <= 1'b0;
      f1_q <= '0;
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      c1_q <= c1_d;
      d1_q <= d1_d;
      f1_q <= f1_d;
    end
  end
  assign v[1]  = v1_q;
  assign a[1]  = a1_q;
  assign c[1]  = c1_q;
  assign d[1]  = d1_q;
  assign fa[1] = f1_q;
  assign tb[1] = f1_q;
  genvar k;
  for (k = 2; k <= DEPTH; k++) begin : g_stage
    bm_dag_stage #(.WIDTH(WIDTH)) u_stage (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (en),
      .flush  (flush),
      .v_in   (v[k-1]),
      .c_in   (c[k-1]),
      .d_in   (d[k-1]),
      .a_in   (a[k-1]),
      .fa_in  (fa[k-1]),
      .tb_in  (tb[k-1]),
      .v_out  (v[k]),
      .c_out  (c[k]),
      .d_out  (d[k]),
      .a_out  (a[k]),
      .fa_out (fa[k]),
      .tb_out (tb[k])
    );
  end
  // the last stage's a is only needed inside that stage
  assign a_unused = ^a[DEPTH];
  // output stage: data moves only when a valid token lands, so bubbles leave out0/out1 intact
  always_comb begin
    up    = ld & v[DEPTH];
    vo_d  = flush ? 1'b0 : en ? v[DEPTH] : vo_q;
    o0_d  = up ? fa[DEPTH] & tb[DEPTH] : o0_q;
    o1_d  = up ? c[DEPTH] & d[DEPTH] : o1_q;
    cnt_d = cnt_q + CNT_W'(vo_q & out_ready);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vo_q  <= 1'b0;
      o0_q  <= '0;
      o1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      vo_q  <= vo_d;
      o0_q  <= o0_d;
      o1_q  <= o1_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = vo_q;
  assign out0      = o0_q;
  assign out1      = o1_q;
  assign out_count = cnt_q;
endmodule
